// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the AHB output-stage arbiter: HTRANS / HBURST
// encodings, arbitration mode selectors and the burst-length helper used
// by the burst tracker.
package ahb_arb_pkg;

    typedef logic [1:0] htrans_t;
    typedef logic [2:0] hburst_t;

    localparam htrans_t HTRANS_IDLE   = 2'b00;
    localparam htrans_t HTRANS_BUSY   = 2'b01;
    localparam htrans_t HTRANS_NONSEQ = 2'b10;
    localparam htrans_t HTRANS_SEQ    = 2'b11;

    localparam hburst_t HBURST_SINGLE = 3'b000;
    localparam hburst_t HBURST_INCR   = 3'b001;
    localparam hburst_t HBURST_WRAP4  = 3'b010;
    localparam hburst_t HBURST_INCR4  = 3'b011;
    localparam hburst_t HBURST_WRAP8  = 3'b100;
    localparam hburst_t HBURST_INCR8  = 3'b101;
    localparam hburst_t HBURST_WRAP16 = 3'b110;
    localparam hburst_t HBURST_INCR16 = 3'b111;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    // Number of SEQ beats that still hold the grant after the NONSEQ beat,
    // excluding the final beat (the hold drops while the last SEQ is seen).
    function automatic logic [3:0] burst_remain_init(input hburst_t hburst,
                                                     input logic [3:0] incr_remain);
        logic [3:0] r;
        case (hburst)
            HBURST_INCR:                 r = incr_remain;
            HBURST_WRAP4,  HBURST_INCR4: r = 4'd2;
            HBURST_WRAP8,  HBURST_INCR8: r = 4'd6;
            HBURST_WRAP16, HBURST_INCR16: r = 4'd14;
            default:                     r = 4'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ahb_out_arbiter_param_if.sv
// Bus bundle between the input stages / routed slave port and the output
// arbiter.
//   req           per-port request from the input stages
//   HREADYM       output-port transfer done, qualifies all updates
//   HSELM/HTRANSM/HBURSTM/HMASTLOCKM  control of the currently routed port
//   addr_in_port  granted port index
//   no_port       no port selected
//   grant_onehot  one-hot grant, all zero when no_port=1
interface ahb_out_arbiter_param_if #(
    parameter int NUM_PORTS = 4,
    parameter int PW        = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
);
    logic [NUM_PORTS-1:0] req;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PW-1:0]        addr_in_port;
    logic                 no_port;
    logic [NUM_PORTS-1:0] grant_onehot;

    modport master (
        output req, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port, grant_onehot
    );

    modport slave (
        input  req, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port, grant_onehot
    );
endinterface

// File: rtl/ahb_arb_burst_tracker.sv
// Burst tracker for the output arbiter. Follows the routed port's transfers
// and reports whether the grant must be held through the next edge.
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   hready          register update enable
//   hsel/htrans/hburst  routed port control
//   next_hold       combinational next value of the hold flag
module ahb_arb_burst_tracker
    import ahb_arb_pkg::*;
#(
    parameter int INCR_HOLD_BEATS = 4,
    parameter int EARLY_INCR_MAX  = 1
) (
    input  logic    HCLK,
    input  logic    HRESETn,
    input  logic    hready,
    input  logic    hsel,
    input  htrans_t htrans,
    input  hburst_t hburst,
    output logic    next_hold
);
    localparam logic [3:0] INCR_REMAIN = 4'(INCR_HOLD_BEATS - 2);
    localparam logic [1:0] EARLY_MAX   = 2'(EARLY_INCR_MAX);

    logic [3:0] remain_q, remain_d;
    logic       hold_q, hold_d;
    logic [1:0] early_cnt_q, early_cnt_d;

    always_comb begin
        remain_d = remain_q;
        hold_d   = hold_q;
        if (!hsel) begin
            remain_d = '0;
            hold_d   = 1'b0;
        end else begin
            case (htrans)
                HTRANS_BUSY: begin
                    // BUSY stretches the burst without consuming a beat
                end
                HTRANS_SEQ: begin
                    if (remain_q == 4'd0) hold_d = 1'b0;
                    else                  remain_d = remain_q - 4'd1;
                end
                HTRANS_NONSEQ: begin
                    // After too many short INCR bursts in a row, INCR stops
                    // holding so one port cannot starve the others.
                    if (hburst == HBURST_SINGLE ||
                        (hburst == HBURST_INCR && early_cnt_q == EARLY_MAX)) begin
                        remain_d = '0;
                        hold_d   = 1'b0;
                    end else begin
                        remain_d = burst_remain_init(hburst, INCR_REMAIN);
                        hold_d   = 1'b1;
                    end
                end
                default: begin
                    remain_d = '0;
                    hold_d   = 1'b0;
                end
            endcase
        end
    end

    // A NONSEQ arriving while still holding means the previous burst was cut short
    always_comb begin
        early_cnt_d = early_cnt_q;
        if (!hold_d)
            early_cnt_d = '0;
        else if (hold_q && htrans == HTRANS_NONSEQ && early_cnt_q != 2'd3)
            early_cnt_d = early_cnt_q + 2'd1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            remain_q    <= '0;
            hold_q      <= 1'b0;
            early_cnt_q <= '0;
        end else if (hready) begin
            remain_q    <= remain_d;
            hold_q      <= hold_d;
            early_cnt_q <= early_cnt_d;
        end
    end

    assign next_hold = hold_d;
endmodule

// File: rtl/ahb_out_arbiter_param.sv
// Parametrised output-stage arbiter for the AHB bus matrix: selects which
// input port drives the shared slave output.
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   bus (slave)    req / routed-port control in, addr_in_port / no_port /
//                  grant_onehot out
module ahb_out_arbiter_param
    import ahb_arb_pkg::*;
#(
    parameter int                   NUM_PORTS       = 4,
    parameter logic [NUM_PORTS-1:0] PORT_MASK       = '1,
    parameter int                   ARB_MODE        = 0,
    parameter int                   INCR_HOLD_BEATS = 4,
    parameter int                   EARLY_INCR_MAX  = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_out_arbiter_param_if.slave bus
);
    localparam int PW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

    logic                 next_hold;
    logic [NUM_PORTS-1:0] mreq;
    logic [PW-1:0]        addr_in_port_q, addr_in_port_d;
    logic                 no_port_q, no_port_d;
    logic [PW-1:0]        lowest_idx, above_idx, below_idx, rot_idx, pick_idx;
    logic                 lowest_found, above_found, below_found, rot_found, pick_found;

    ahb_arb_burst_tracker #(
        .INCR_HOLD_BEATS (INCR_HOLD_BEATS),
        .EARLY_INCR_MAX  (EARLY_INCR_MAX)
    ) u_tracker (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .hready    (bus.HREADYM),
        .hsel      (bus.HSELM),
        .htrans    (bus.HTRANSM),
        .hburst    (bus.HBURSTM),
        .next_hold (next_hold)
    );

    assign mreq = bus.req & PORT_MASK;

    // Descending scan: the last hit is the lowest index in each class.
    // "above" is the first port after the current one, "below" the first
    // port after wrapping; together they form the round-robin order.
    always_comb begin
        lowest_found = 1'b0;
        lowest_idx   = '0;
        above_found  = 1'b0;
        above_idx    = '0;
        below_found  = 1'b0;
        below_idx    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (mreq[i]) begin
                lowest_found = 1'b1;
                lowest_idx   = PW'(i);
                if (PW'(i) > addr_in_port_q) begin
                    above_found = 1'b1;
                    above_idx   = PW'(i);
                end
                if (PW'(i) < addr_in_port_q) begin
                    below_found = 1'b1;
                    below_idx   = PW'(i);
                end
            end
        end
    end

    assign rot_found  = above_found | below_found;
    assign rot_idx    = above_found ? above_idx : below_idx;
    assign pick_found = (ARB_MODE == ARB_MODE_FIXED) ? lowest_found : rot_found;
    assign pick_idx   = (ARB_MODE == ARB_MODE_FIXED) ? lowest_idx   : rot_idx;

    // Using next_hold keeps the grant through the last beat of a burst
    always_comb begin
        addr_in_port_d = addr_in_port_q;
        no_port_d      = no_port_q;
        if (bus.HMASTLOCKM || next_hold) begin
            no_port_d = 1'b0;
        end else if (no_port_q) begin
            if (lowest_found) begin
                addr_in_port_d = lowest_idx;
                no_port_d      = 1'b0;
            end
        end else if (pick_found) begin
            addr_in_port_d = pick_idx;
        end else if (!bus.HSELM) begin
            no_port_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port_q <= '0;
            no_port_q      <= 1'b1;
        end else if (bus.HREADYM) begin
            addr_in_port_q <= addr_in_port_d;
            no_port_q      <= no_port_d;
        end
    end

    always_comb begin
        bus.grant_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            bus.grant_onehot[i] = !no_port_q && (addr_in_port_q == PW'(i));
    end

    assign bus.addr_in_port = addr_in_port_q;
    assign bus.no_port      = no_port_q;
endmodule

// File: tb/tb_ahb_out_arbiter_param.sv
// Bench for ahb_out_arbiter_param: three configurations driven from one
// shared stimulus, checked against constant vector tables, hand sequences
// and a behavioural model of the arbitration rules.
module tb_ahb_out_arbiter_param;

    typedef struct {
        int n; int mask; int mode; int hold_beats; int early_max;
    } cfg_t;

    typedef struct {
        int remain; bit hold; int early; int port; bit idle;
    } mst_t;

    typedef struct {
        bit pre_rst; int dut; int rq; bit rdy; bit sel; int tr; int bu; bit lk;
        int ep; bit en;
    } vec_t;

    localparam int I = 0, B = 1, N = 2, S = 3;

    logic        clk;
    logic        rstn;
    logic [15:0] req_s;
    logic        rdy_s, sel_s, lock_s;
    logic [1:0]  trans_s;
    logic [2:0]  burst_s;

    int   nvec  = 0;
    int   nfail = 0;
    cfg_t cfg[3];
    mst_t ms[3];
    mst_t nx[3];
    vec_t tbl[$];

    ahb_out_arbiter_param_if #(.NUM_PORTS(4)) if0 ();
    ahb_out_arbiter_param_if #(.NUM_PORTS(4)) if1 ();
    ahb_out_arbiter_param_if #(.NUM_PORTS(2)) if2 ();

    assign if0.req = req_s[3:0];
    assign if1.req = req_s[3:0];
    assign if2.req = req_s[1:0];
    assign {if0.HREADYM, if1.HREADYM, if2.HREADYM} = {3{rdy_s}};
    assign {if0.HSELM, if1.HSELM, if2.HSELM} = {3{sel_s}};
    assign {if0.HMASTLOCKM, if1.HMASTLOCKM, if2.HMASTLOCKM} = {3{lock_s}};
    assign {if0.HTRANSM, if1.HTRANSM, if2.HTRANSM} = {3{trans_s}};
    assign {if0.HBURSTM, if1.HBURSTM, if2.HBURSTM} = {3{burst_s}};

    ahb_out_arbiter_param #(.NUM_PORTS(4), .PORT_MASK(4'b1111), .ARB_MODE(0),
        .INCR_HOLD_BEATS(4), .EARLY_INCR_MAX(1))
        dut0 (.HCLK(clk), .HRESETn(rstn), .bus(if0));
    ahb_out_arbiter_param #(.NUM_PORTS(4), .PORT_MASK(4'b1101), .ARB_MODE(1),
        .INCR_HOLD_BEATS(6), .EARLY_INCR_MAX(2))
        dut1 (.HCLK(clk), .HRESETn(rstn), .bus(if1));
    ahb_out_arbiter_param #(.NUM_PORTS(2), .PORT_MASK(2'b11), .ARB_MODE(0),
        .INCR_HOLD_BEATS(2), .EARLY_INCR_MAX(3))
        dut2 (.HCLK(clk), .HRESETn(rstn), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: burst length in beats decides how long the grant is held;
    // arbitration picks the first requesting port in rotation order.
    function automatic mst_t model_next(cfg_t c, mst_t s, int rq, bit sel,
                                        int tr, int bu, bit lk);
        mst_t n;
        int   beats;
        int   mq;
        int   pick;
        n = s;
        if (!sel || tr == I) begin
            n.remain = 0; n.hold = 0;
        end else if (tr == S) begin
            if (s.remain == 0) n.hold = 0;
            else n.remain = s.remain - 1;
        end else if (tr == N) begin
            case (bu)
                0:       beats = 1;
                1:       beats = (s.early == c.early_max) ? 1 : c.hold_beats;
                2, 3:    beats = 4;
                4, 5:    beats = 8;
                default: beats = 16;
            endcase
            if (beats == 1) begin n.remain = 0; n.hold = 0; end
            else begin n.remain = beats - 2; n.hold = 1; end
        end
        if (!n.hold) n.early = 0;
        else if (s.hold && tr == N) n.early = (s.early >= 3) ? 3 : s.early + 1;

        mq   = rq & c.mask & ((1 << c.n) - 1);
        pick = -1;
        if (lk || n.hold) begin
            n.idle = 0;
        end else begin
            if (s.idle || c.mode == 1) begin
                for (int i = c.n - 1; i >= 0; i--) if (mq[i]) pick = i;
            end else begin
                for (int k = c.n - 1; k >= 1; k--)
                    if (mq[(s.port + k) % c.n]) pick = (s.port + k) % c.n;
            end
            if (pick >= 0) begin
                n.port = pick; n.idle = 0;
            end else if (!s.idle && !sel) begin
                n.idle = 1;
            end
        end
        return n;
    endfunction

    task automatic check_dut(int d, string tag, int ep, bit ei);
        int gp, go, eo;
        bit gi;
        case (d)
            0:       begin gp = int'(if0.addr_in_port); gi = if0.no_port; go = int'(if0.grant_onehot); end
            1:       begin gp = int'(if1.addr_in_port); gi = if1.no_port; go = int'(if1.grant_onehot); end
            default: begin gp = int'(if2.addr_in_port); gi = if2.no_port; go = int'(if2.grant_onehot); end
        endcase
        eo = ei ? 0 : (1 << ep);
        nvec++;
        if (gp != ep || gi != ei || go != eo) begin
            nfail++;
            $display("FAIL %s dut%0d @%0t: got port=%0d no_port=%0b onehot=%0h, want port=%0d no_port=%0b onehot=%0h",
                     tag, d, $time, gp, gi, go, ep, ei, eo);
        end
    endtask

    task automatic drive(int rq, bit rdy, bit sel, int tr, int bu, bit lk);
        req_s   = rq[15:0];
        rdy_s   = rdy;
        sel_s   = sel;
        trans_s = tr[1:0];
        burst_s = bu[2:0];
        lock_s  = lk;
    endtask

    task automatic tick(string tag);
        for (int d = 0; d < 3; d++)
            nx[d] = rdy_s ? model_next(cfg[d], ms[d], int'(req_s), sel_s,
                                       int'(trans_s), int'(burst_s), lock_s)
                          : ms[d];
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            ms[d] = nx[d];
            check_dut(d, tag, ms[d].port, ms[d].idle);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            ms[d] = '{0, 1'b0, 0, 0, 1'b1};
            check_dut(d, "reset", 0, 1'b1);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    task automatic add(bit pr, int d, int rq, bit rdy, bit sel, int tr, int bu,
                       bit lk, int ep, bit en);
        tbl.push_back('{pr, d, rq, rdy, sel, tr, bu, lk, ep, en});
    endtask

    initial begin
        cfg[0] = '{4, 'hF, 0, 4, 1};
        cfg[1] = '{4, 'hD, 1, 6, 2};
        cfg[2] = '{2, 'h3, 0, 2, 3};
        rstn = 1'b0;
        drive(0, 1, 0, I, 0, 0);

        // dut0: first grant, rotation with wrap, INCR8 hold, BUSY stretch,
        // early INCR limit, HREADYM stalls, HSELM keep / release
        add(1, 0, 'h0, 1, 0, I, 0, 0, 0, 1);
        add(0, 0, 'h4, 1, 0, I, 0, 0, 2, 0);
        add(0, 0, 'h8, 1, 0, I, 0, 0, 3, 0);
        add(0, 0, 'hB, 1, 0, I, 0, 0, 0, 0);
        add(0, 0, 'hB, 1, 0, I, 0, 0, 1, 0);
        add(0, 0, 'hF, 1, 1, N, 5, 0, 1, 0);
        for (int k = 0; k < 6; k++) add(0, 0, 'hF, 1, 1, S, 5, 0, 1, 0);
        add(0, 0, 'hF, 1, 1, S, 5, 0, 2, 0);
        add(0, 0, 'h2, 1, 0, I, 0, 0, 1, 0);
        add(0, 0, 'hF, 1, 1, N, 3, 0, 1, 0);
        add(0, 0, 'hF, 1, 1, S, 3, 0, 1, 0);
        add(0, 0, 'hF, 1, 1, B, 3, 0, 1, 0);
        add(0, 0, 'hF, 1, 1, S, 3, 0, 1, 0);
        add(0, 0, 'hF, 1, 1, S, 3, 0, 2, 0);
        add(0, 0, 'h1, 1, 0, I, 0, 0, 0, 0);
        add(0, 0, 'h9, 1, 1, N, 1, 0, 0, 0);
        add(0, 0, 'h9, 1, 1, S, 1, 0, 0, 0);
        add(0, 0, 'h9, 1, 1, N, 1, 0, 0, 0);
        add(0, 0, 'h9, 1, 1, S, 1, 0, 0, 0);
        add(0, 0, 'h9, 1, 1, N, 1, 0, 3, 0);
        add(0, 0, 'h1, 0, 0, I, 0, 0, 3, 0);
        add(0, 0, 'h0, 0, 0, I, 0, 0, 3, 0);
        add(0, 0, 'h0, 1, 0, I, 0, 0, 3, 1);
        add(0, 0, 'h0, 1, 0, I, 0, 0, 3, 1);
        add(0, 0, 'h2, 1, 0, I, 0, 0, 1, 0);
        add(0, 0, 'h0, 1, 1, I, 0, 0, 1, 0);
        add(0, 0, 'h2, 1, 0, I, 0, 0, 1, 1);
        // dut1: masked port never granted, fixed priority, lock
        add(1, 1, 'h2, 1, 0, I, 0, 0, 0, 1);
        add(0, 1, 'h2, 1, 0, I, 0, 0, 0, 1);
        add(0, 1, 'h4, 1, 0, I, 0, 0, 2, 0);
        add(0, 1, 'h5, 1, 1, I, 0, 0, 0, 0);
        add(0, 1, 'h4, 1, 1, I, 0, 0, 2, 0);
        add(0, 1, 'h5, 1, 1, I, 0, 1, 2, 0);
        add(0, 1, 'h5, 1, 1, I, 0, 1, 2, 0);
        add(0, 1, 'h5, 1, 1, I, 0, 0, 0, 0);
        // dut2: two ports, one-bit index must wrap
        add(1, 2, 'h2, 1, 0, I, 0, 0, 1, 0);
        add(0, 2, 'h3, 1, 0, I, 0, 0, 0, 0);
        add(0, 2, 'h3, 1, 0, I, 0, 0, 1, 0);
        add(0, 2, 'h3, 1, 0, I, 0, 0, 0, 0);
        add(0, 2, 'h1, 1, 0, I, 0, 0, 0, 1);

        foreach (tbl[j]) begin
            if (tbl[j].pre_rst) do_reset();
            drive(tbl[j].rq, tbl[j].rdy, tbl[j].sel, tbl[j].tr, tbl[j].bu, tbl[j].lk);
            tick("model");
            check_dut(tbl[j].dut, "vector", tbl[j].ep, tbl[j].en);
        end

        // Reset in the middle of an INCR16 burst drops the hold at once
        do_reset();
        drive('h4, 1, 0, I, 0, 0); tick("mrst"); check_dut(0, "mrst_grant", 2, 0);
        drive('hF, 1, 1, N, 7, 0); tick("mrst"); check_dut(0, "mrst_nonseq", 2, 0);
        drive('hF, 1, 1, S, 7, 0); tick("mrst"); check_dut(0, "mrst_seq", 2, 0);
        do_reset();
        drive('h8, 1, 1, S, 7, 0); tick("mrst"); check_dut(0, "mrst_release", 3, 0);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            drive(int'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 15) == 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
